mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response buses for the fetch and data ports plus the unified memory port of mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_funct3,
               mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_funct3,
               mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port, data-first with fetch anti-starvation; MEM_ARB_STATS_EN adds counters.
// Latency: ready pulse MEM_LAT+2 cycles after the grant decision; one access per MEM_LAT+3 cycles.
// Backpressure: requesters hold req until their one-cycle ready; stall flags any unserved request.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]  stat_if_cnt,
    output logic [31:0]  stat_d_cnt,
    output logic [31:0]  stat_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state, state_nxt;
    logic [3:0]  lat_cnt;
    logic [2:0]  starve_cnt;
    logic        sel_if;
    logic        acc_we;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        grant_if, grant_d, capture;
    logic        mem_en, if_ready, d_ready, stall;

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        capture   = 1'b0;
        mem_en    = 1'b0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_nxt = GRANT;
                    if (bus.if_req && (!bus.d_req || starve_cnt == STARVE_LIM))
                        grant_if = 1'b1;
                    else
                        grant_d = 1'b1;
                end
            end
            GRANT: begin
                mem_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_ready  = sel_if;
                d_ready   = !sel_if;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt    <= 4'd0;
            starve_cnt <= 3'd0;
            sel_if     <= 1'b0;
            acc_we     <= 1'b0;
            acc_funct3 <= 3'b010;
            acc_addr   <= 32'h0;
            acc_wdata  <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (grant_if) begin
                sel_if     <= 1'b1;
                acc_we     <= 1'b0;
                acc_funct3 <= 3'b010;
                acc_addr   <= bus.if_addr;
            end
            if (grant_d) begin
                sel_if     <= 1'b0;
                acc_we     <= bus.d_we;
                acc_funct3 <= bus.d_funct3;
                acc_addr   <= bus.d_addr;
                acc_wdata  <= bus.d_wdata;
            end
            // A data win only counts against fetch while fetch is actually waiting.
            if (state == IDLE) begin
                if (grant_if || !bus.if_req)
                    starve_cnt <= 3'd0;
                else if (grant_d && starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 3'd1;
            end
            if (state == GRANT)
                lat_cnt <= LAT_LOAD;
            else if (state == WAIT && lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;
            if (capture) begin
                if (sel_if)
                    if_rdata_q <= bus.mem_rdata;
                else if (!acc_we)
                    d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign stall          = (bus.if_req & ~if_ready) | (bus.d_req & ~d_ready);
    assign bus.stall      = stall;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_en & acc_we;
    assign bus.mem_funct3 = acc_funct3;
    assign bus.mem_addr   = acc_addr;
    assign bus.mem_wdata  = acc_wdata;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.if_ready   = if_ready;
    assign bus.d_ready    = d_ready;

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_cnt    <= 32'h0;
            stat_d_cnt     <= 32'h0;
            stat_stall_cnt <= 32'h0;
        end else begin
            if (grant_if && stat_if_cnt != 32'hFFFF_FFFF)
                stat_if_cnt <= stat_if_cnt + 32'd1;
            if (grant_d && stat_d_cnt != 32'hFFFF_FFFF)
                stat_d_cnt <= stat_d_cnt + 32'd1;
            if (stall && stat_stall_cnt != 32'hFFFF_FFFF)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-requester traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_cnt, stat_d_cnt, stat_stall_cnt;
`endif

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_cnt    (stat_if_cnt),
        .stat_d_cnt     (stat_d_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_d_rdata = 32'h0;

    // Memory environment: stores land at mem_en, read data is valid only MEM_LAT cycles later.
    logic [31:0] mem_model [logic [31:0]];
    int          rd_cnt = 0;
    logic [31:0] rd_addr = 32'h0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            rd_cnt        = 0;
            bus.mem_rdata = $urandom;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
            rd_addr       = bus.mem_addr;
            rd_cnt        = MEM_LAT;
            bus.mem_rdata = $urandom;
        end else if (rd_cnt > 0) begin
            rd_cnt        = rd_cnt - 1;
            bus.mem_rdata = (rd_cnt == 0) ? mem_read(rd_addr) : $urandom;
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.stall} !== 5'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00000",
                              {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready, bus.stall});
        end
        n_cmp++;
        if (bus.mem_funct3 !== 3'b010) begin
            n_err++; $display("FAIL reset_funct3: got %b want 010", bus.mem_funct3);
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_mem_fields: got %h %h want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h want 0 0", bus.if_rdata, bus.d_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        logic [2:0] exp_v;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1;
        n_cmp++;
        if ({bus.stall, bus.mem_en} !== 2'b10) begin
            n_err++; $display("FAIL fetch_c0: got stall/mem_en=%b want 10", {bus.stall, bus.mem_en});
        end
        for (int c = 1; c <= MEM_LAT + 2; c++) begin
            @(negedge clk);
            exp_v = {c == 1, c == MEM_LAT + 2, c < MEM_LAT + 2};
            n_cmp++;
            if ({bus.mem_en, bus.if_ready, bus.stall} !== exp_v) begin
                n_err++; $display("FAIL fetch_c%0d: got mem_en/if_ready/stall=%b want %b",
                                  c, {bus.mem_en, bus.if_ready, bus.stall}, exp_v);
            end
            if (c == 1) begin
                n_cmp++;
                if ({bus.mem_addr, bus.mem_funct3, bus.mem_we} !== {32'h10, 3'b010, 1'b0}) begin
                    n_err++; $display("FAIL fetch_fields: got %h/%b/%b want 00000010/010/0",
                                      bus.mem_addr, bus.mem_funct3, bus.mem_we);
                end
            end
        end
        n_cmp++;
        if (bus.if_rdata !== mem_read(32'h10)) begin
            n_err++; $display("FAIL fetch_rdata: got %h want %h", bus.if_rdata, mem_read(32'h10));
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_funct3 = 3'b100;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_en, bus.mem_addr, bus.mem_funct3, bus.mem_we} !== {1'b1, 32'h20, 3'b100, 1'b0}) begin
            n_err++; $display("FAIL prio_data_first: got en=%b addr=%h f3=%b we=%b want 1/20/100/0",
                              bus.mem_en, bus.mem_addr, bus.mem_funct3, bus.mem_we);
        end
        repeat (MEM_LAT + 1) @(negedge clk);
        n_cmp++;
        if ({bus.d_ready, bus.if_ready, bus.d_rdata} !== {2'b10, mem_read(32'h20)}) begin
            n_err++; $display("FAIL prio_d_done: got rdy=%b%b data=%h want 10 %h",
                              bus.d_ready, bus.if_ready, bus.d_rdata, mem_read(32'h20));
        end
        exp_d_rdata = mem_read(32'h20);
        bus.d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_en !== 1'b0) begin
            n_err++; $display("FAIL prio_idle: got mem_en=%b want 0", bus.mem_en);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_en, bus.mem_addr, bus.mem_funct3, bus.mem_we} !== {1'b1, 32'h40, 3'b010, 1'b0}) begin
            n_err++; $display("FAIL prio_fetch_next: got en=%b addr=%h f3=%b we=%b want 1/40/010/0",
                              bus.mem_en, bus.mem_addr, bus.mem_funct3, bus.mem_we);
        end
        repeat (MEM_LAT + 1) @(negedge clk);
        n_cmp++;
        if ({bus.if_ready, bus.if_rdata} !== {1'b1, mem_read(32'h40)}) begin
            n_err++; $display("FAIL prio_fetch_done: got rdy=%b data=%h want 1 %h",
                              bus.if_ready, bus.if_rdata, mem_read(32'h40));
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int  g;
        bit  seen;
        g = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_funct3 = 3'b010;
        for (int k = 0; k < 100 && g < 5; k++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                n_cmp++;
                if ((bus.mem_addr == 32'h100) !== (g == STARVE_MAX)) begin
                    n_err++; $display("FAIL starve_grant%0d: got %s want %s", g,
                                      (bus.mem_addr == 32'h100) ? "I" : "D", (g == STARVE_MAX) ? "I" : "D");
                end
                g++;
            end
        end
        if (g < 5) begin
            n_cmp++; n_err++; $display("FAIL starve_timeout: got %0d grants want 5", g);
        end
        seen = 1'b0;
        for (int k = 0; k < MEM_LAT + 3 && !seen; k++) begin
            @(negedge clk);
            seen = bus.d_ready;
        end
        n_cmp++;
        if ({seen, bus.d_rdata} !== {1'b1, mem_read(32'h200)}) begin
            n_err++; $display("FAIL starve_last_load: got rdy=%b data=%h want 1 %h",
                              seen, bus.d_rdata, mem_read(32'h200));
        end
        exp_d_rdata = mem_read(32'h200);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        logic [2:0] exp_v;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'hDEADBEEF; bus.d_funct3 = 3'b010;
        for (int c = 1; c <= MEM_LAT + 2; c++) begin
            @(negedge clk);
            exp_v = {c == 1, c == 1, c == MEM_LAT + 2};
            n_cmp++;
            if ({bus.mem_en, bus.mem_we, bus.d_ready} !== exp_v) begin
                n_err++; $display("FAIL store_c%0d: got en/we/d_ready=%b want %b",
                                  c, {bus.mem_en, bus.mem_we, bus.d_ready}, exp_v);
            end
            if (c == 1) begin
                n_cmp++;
                if ({bus.mem_addr, bus.mem_wdata} !== {32'h8, 32'hDEADBEEF}) begin
                    n_err++; $display("FAIL store_fields: got %h/%h want 00000008/deadbeef",
                                      bus.mem_addr, bus.mem_wdata);
                end
            end
        end
        n_cmp++;
        if (bus.d_rdata !== exp_d_rdata) begin
            n_err++; $display("FAIL store_rdata_held: got %h want %h", bus.d_rdata, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        repeat (MEM_LAT + 2) @(negedge clk);
        n_cmp++;
        if ({bus.d_ready, bus.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL store_readback: got rdy=%b data=%h want 1 deadbeef", bus.d_ready, bus.d_rdata);
        end
        exp_d_rdata = 32'hDEADBEEF;
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_v;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_en, bus.if_ready, bus.d_ready, bus.mem_addr, bus.if_rdata} !== {3'b000, 64'h0}) begin
            n_err++; $display("FAIL rstmid_immediate: got en/rdy=%b%b%b addr=%h if_rdata=%h want 000 0 0",
                              bus.mem_en, bus.if_ready, bus.d_ready, bus.mem_addr, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44; bus.d_funct3 = 3'b000;
        for (int c = 1; c <= MEM_LAT + 2; c++) begin
            @(negedge clk);
            exp_v = {c == 1, 1'b0, c == MEM_LAT + 2};
            n_cmp++;
            if ({bus.mem_en, bus.if_ready, bus.d_ready} !== exp_v) begin
                n_err++; $display("FAIL rstmid_c%0d: got en/if_rdy/d_rdy=%b want %b",
                                  c, {bus.mem_en, bus.if_ready, bus.d_ready}, exp_v);
            end
        end
        n_cmp++;
        if (bus.d_rdata !== mem_read(32'h44)) begin
            n_err++; $display("FAIL rstmid_load: got %h want %h", bus.d_rdata, mem_read(32'h44));
        end
        exp_d_rdata = mem_read(32'h44);
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        f_act, d_act, prev_f, prev_d, busy, win_f, exp_f;
        logic        d_we_r;
        logic [2:0]  d_f3;
        logic [31:0] f_addr, d_addr_r, d_wd, exp_r;
        int          f_gap, d_gap, starve, grant_c, done_n;
        f_act = 0; d_act = 0; prev_f = 0; prev_d = 0; busy = 0; win_f = 0;
        f_gap = 1; d_gap = 1; starve = 0; grant_c = 0; done_n = 0;
        f_addr = 0; d_addr_r = 0; d_wd = 0; d_we_r = 0; d_f3 = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_cmp++;
            if ($countones({bus.mem_en, bus.if_ready, bus.d_ready}) > 1) begin
                n_err++; $display("FAIL rnd_exclusive@%0d: got en/if_rdy/d_rdy=%b want at most one",
                                  c, {bus.mem_en, bus.if_ready, bus.d_ready});
            end
            n_cmp++;
            if (bus.stall !== ((f_act & ~bus.if_ready) | (d_act & ~bus.d_ready))) begin
                n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", c, bus.stall,
                                  (f_act & ~bus.if_ready) | (d_act & ~bus.d_ready));
            end
            if (bus.mem_en) begin
                exp_f = prev_f && (!prev_d || starve == STARVE_MAX);
                n_cmp++;
                if (busy || !(prev_f || prev_d) ||
                    (exp_f && {bus.mem_addr, bus.mem_we, bus.mem_funct3} !== {f_addr, 1'b0, 3'b010}) ||
                    (!exp_f && {bus.mem_addr, bus.mem_we, bus.mem_funct3} !== {d_addr_r, d_we_r, d_f3}) ||
                    (!exp_f && d_we_r && bus.mem_wdata !== d_wd)) begin
                    n_err++; $display("FAIL rnd_grant@%0d: got addr=%h we=%b f3=%b want %s addr=%h (busy=%b)",
                                      c, bus.mem_addr, bus.mem_we, bus.mem_funct3, exp_f ? "fetch" : "data",
                                      exp_f ? f_addr : d_addr_r, busy);
                end
                if (exp_f)       starve = 0;
                else if (prev_f) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
                else             starve = 0;
                busy = 1; win_f = exp_f; grant_c = c;
            end else if (bus.if_ready || bus.d_ready) begin
                n_cmp++;
                if (!busy || {bus.if_ready, bus.d_ready} !== {win_f, !win_f} || c != grant_c + MEM_LAT + 1) begin
                    n_err++; $display("FAIL rnd_ready@%0d: got rdy=%b%b want %b%b at cycle %0d",
                                      c, bus.if_ready, bus.d_ready, win_f, !win_f, grant_c + MEM_LAT + 1);
                end
                exp_r = win_f ? mem_read(f_addr) : (d_we_r ? exp_d_rdata : mem_read(d_addr_r));
                n_cmp++;
                if ((win_f ? bus.if_rdata : bus.d_rdata) !== exp_r) begin
                    n_err++; $display("FAIL rnd_rdata@%0d: got %h want %h", c,
                                      win_f ? bus.if_rdata : bus.d_rdata, exp_r);
                end
                if (win_f) begin
                    f_act = 0; f_gap = $urandom_range(1, 3);
                end else begin
                    if (!d_we_r) exp_d_rdata = exp_r;
                    d_act = 0; d_gap = $urandom_range(1, 3);
                end
                busy = 0;
                done_n++;
            end else if (busy && c > grant_c + MEM_LAT + 1) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_timeout@%0d: got no ready want one by cycle %0d", c, grant_c + MEM_LAT + 1);
                busy = 0;
                if (win_f) f_act = 0; else d_act = 0;
            end
            if (!f_act) begin
                if (f_gap > 0) f_gap--;
                else if ($urandom_range(0, 1) == 1) begin
                    f_act = 1; f_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                end
            end
            if (!d_act) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 1) == 1) begin
                    d_act = 1; d_addr_r = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    d_we_r = 1'($urandom_range(0, 1)); d_f3 = 3'($urandom_range(0, 7)); d_wd = $urandom;
                end
            end
            bus.if_req = f_act; bus.if_addr = f_addr;
            bus.d_req = d_act; bus.d_we = d_we_r; bus.d_addr = d_addr_r; bus.d_funct3 = d_f3; bus.d_wdata = d_wd;
            prev_f = f_act; prev_d = d_act;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (MEM_LAT + 4) @(negedge clk);
        n_cmp++;
        if (done_n < 40) begin
            n_err++; $display("FAIL rnd_throughput: got %0d completions want at least 40", done_n);
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        force dut.stat_d_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.stat_d_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4; bus.d_funct3 = 3'b010;
        repeat (MEM_LAT + 2) @(negedge clk);
        bus.d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stat_d_cnt !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL stats_saturate: got %h want ffffffff", stat_d_cnt);
        end
    endtask
`endif

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_funct3 = 3'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_store();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500us");
        $fatal(1, "watchdog expired");
    end
endmodule
